// File: rtl/operand_fetch_stage.sv
// RV32I decode / operand-fetch stage: register file addressing, immediate decode,
// operand forwarding, load-use hazard detection and the ID/EX pipeline register.
module operand_fetch_stage #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc,
    output logic                   id_ready,
    output logic [4:0]             rs1_addr,
    output logic [4:0]             rs2_addr,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    input  logic [31:0]            ex_result,
    input  logic                   mem_valid,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_is_load,
    input  logic [31:0]            mem_data,
    input  logic                   wb_write,
    input  logic [4:0]             wb_rd,
    input  logic [31:0]            wb_data,
    input  logic                   ex_ready,
    output logic                   ex_valid,
    output logic [31:0]            ex_pc,
    output logic [31:0]            ex_instr,
    output logic [31:0]            ex_op1,
    output logic [31:0]            ex_op2,
    output logic [31:0]            ex_imm,
    output logic [4:0]             ex_rd,
    output logic                   ex_reg_write,
    output logic                   ex_is_load,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]       opcode;
    logic [4:0]       rd_field;
    logic             uses_rs1;
    logic             uses_rs2;
    logic [31:0]      imm_c;
    logic             reg_write_c;
    logic [1:0][4:0]  src_addr;
    logic [1:0][31:0] rf_data;
    logic [1:0][31:0] op_data;
    logic [1:0]       op_hazard;
    logic             hazard;
    logic             advance;

    assign opcode   = if_instr[6:0];
    assign rd_field = if_instr[11:7];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];
    assign src_addr = {rs2_addr, rs1_addr};
    assign rf_data  = {rf_rdata2, rf_rdata1};

    assign uses_rs1    = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2    = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
    assign reg_write_c = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd_field != 5'd0);

    // Immediate decode, sign-extended from instruction bit 31
    always_comb begin
        imm_c = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM:
                imm_c = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE:
                imm_c = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                imm_c = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_c = {if_instr[31:12], 12'b0};
            OP_JAL:
                imm_c = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            default:
                imm_c = '0;
        endcase
    end

    // Operand select: youngest producer wins; a pending load result is a hazard
    always_comb begin
        op_data   = rf_data;
        op_hazard = '0;
        for (int i = 0; i < 2; i++) begin
            if (src_addr[i] == 5'd0) begin
                op_data[i] = '0;
            end else if (ex_valid && ex_reg_write && ex_rd == src_addr[i]) begin
                op_data[i]   = ex_result;
                op_hazard[i] = ex_is_load;
            end else if (mem_valid && mem_rd == src_addr[i]) begin
                op_data[i]   = mem_data;
                op_hazard[i] = mem_is_load;
            end else if (wb_write && wb_rd == src_addr[i]) begin
                op_data[i] = wb_data;
            end
        end
    end

    assign hazard   = if_valid && ((uses_rs1 && op_hazard[0]) || (uses_rs2 && op_hazard[1]));
    assign advance  = !ex_valid || ex_ready;
    assign id_ready = flush || (advance && !hazard);

    // ID/EX pipeline register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_instr     <= '0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (if_valid && id_ready) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_instr     <= if_instr;
            ex_op1       <= op_data[0];
            ex_op2       <= op_data[1];
            ex_imm       <= imm_c;
            ex_rd        <= reg_write_c ? rd_field : 5'd0;
            ex_reg_write <= reg_write_c;
            ex_is_load   <= (opcode == OP_LOAD);
        end else if (advance) begin
            ex_valid <= 1'b0;
        end
    end

    // Saturating hazard stall counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (hazard && !flush && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, forwarding, load-use, backpressure,
// flush and immediate decode, with hand-computed expected values.
module tb_operand_fetch_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] ex_result;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic [31:0] mem_data;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_is_load;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD_X3  = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] I_SUB_X4  = 32'h4021_8233;  // sub  x4,x3,x2
    localparam logic [31:0] I_LW_X5   = 32'h0000_A283;  // lw   x5,0(x1)
    localparam logic [31:0] I_ADD_X6  = 32'h0052_8333;  // add  x6,x5,x5
    localparam logic [31:0] I_ADD_X7  = 32'h0000_03B3;  // add  x7,x0,x0
    localparam logic [31:0] I_BEQ_M8  = 32'hFE00_0CE3;  // beq  x0,x0,-8
    localparam logic [31:0] I_LUI_X8  = 32'hABCD_E437;  // lui  x8,0xABCDE

    always #5 clock = ~clock;

    operand_fetch_stage #(.STALL_CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_data(mem_data),
        .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_is_load(ex_is_load), .stall_cycles(stall_cycles)
    );

    task automatic idle_inputs();
        flush = 0; if_valid = 0; if_instr = '0; if_pc = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; ex_result = '0;
        mem_valid = 0; mem_rd = '0; mem_is_load = 0; mem_data = '0;
        wb_write = 0; wb_rd = '0; wb_data = '0; ex_ready = 1;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0; if_valid = 1; if_instr = I_ADDI_X1;
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
        checks++; if (ex_op1 !== 32'h0) begin failures++; $display("FAIL reset_ex_op1 got=%h exp=0", ex_op1); end
        checks++; if (stall_cycles !== 16'h0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
        reset_n = 1; if_pc = 32'h100; rf_rdata1 = 32'hDEAD_BEEF;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_id_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", ex_valid); end
        checks++; if (ex_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", ex_imm); end
        checks++; if (ex_rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", ex_rd); end
        checks++; if (ex_op1 !== 32'h0) begin failures++; $display("FAIL addi_op1 got=%h exp=0", ex_op1); end
        checks++; if (ex_pc !== 32'h100) begin failures++; $display("FAIL addi_pc got=%h exp=100", ex_pc); end
        idle_inputs();
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%0b exp=0", ex_valid); end
    endtask

    task automatic test_ex_forward();
        idle_inputs();
        if_valid = 1; if_instr = I_ADD_X3; if_pc = 32'h104;
        tick();
        if_instr = I_SUB_X4; if_pc = 32'h108;
        ex_result = 32'h1234; rf_rdata1 = 32'hDEAD_0001; rf_rdata2 = 32'd7;
        #1;
        checks++; if (rs1_addr !== 5'd3 || rs2_addr !== 5'd2) begin failures++; $display("FAIL fwd_addrs got=%0d,%0d exp=3,2", rs1_addr, rs2_addr); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL fwd_id_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_op1 !== 32'h1234) begin failures++; $display("FAIL fwd_op1 got=%h exp=1234", ex_op1); end
        checks++; if (ex_op2 !== 32'd7) begin failures++; $display("FAIL fwd_op2 got=%h exp=7", ex_op2); end
        checks++; if (ex_rd !== 5'd4) begin failures++; $display("FAIL fwd_rd got=%0d exp=4", ex_rd); end
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL fwd_stall got=%0d exp=0", stall_cycles); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        if_valid = 1; if_instr = I_LW_X5; if_pc = 32'h10C;
        tick();
        checks++; if (ex_is_load !== 1'b1) begin failures++; $display("FAIL lw_is_load got=%0b exp=1", ex_is_load); end
        // dependent waits while the load sits in ID/EX
        if_instr = I_ADD_X6; if_pc = 32'h110; rf_rdata1 = 32'h1111; rf_rdata2 = 32'h2222;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_ready1 got=%0b exp=0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble1 got=%0b exp=0", ex_valid); end
        // then while it sits in EX/MEM
        mem_valid = 1; mem_rd = 5'd5; mem_is_load = 1; mem_data = 32'h9999;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_ready2 got=%0b exp=0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble2 got=%0b exp=0", ex_valid); end
        checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL lu_stall got=%0d exp=2", stall_cycles); end
        mem_valid = 0; mem_is_load = 0;
        wb_write = 1; wb_rd = 5'd5; wb_data = 32'hCAFE;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_ready3 got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL lu_issue got=%0b exp=1", ex_valid); end
        checks++; if (ex_op1 !== 32'hCAFE || ex_op2 !== 32'hCAFE) begin failures++; $display("FAIL lu_ops got=%h,%h exp=cafe,cafe", ex_op1, ex_op2); end
        checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL lu_stall_after got=%0d exp=2", stall_cycles); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        ex_ready = 0; if_valid = 1; if_instr = I_ADDI_X1; if_pc = 32'h114;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got=%0b exp=0", i, id_ready); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_instr !== I_ADD_X6) begin failures++; $display("FAIL bp_hold%0d got=%0b/%h exp=1/%h", i, ex_valid, ex_instr, I_ADD_X6); end
        end
        ex_ready = 1;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_instr !== I_ADDI_X1 || ex_pc !== 32'h114) begin failures++; $display("FAIL bp_load got=%h/%h exp=%h/114", ex_instr, ex_pc, I_ADDI_X1); end
    endtask

    task automatic test_flush();
        idle_inputs();
        if_valid = 1; if_instr = I_LW_X5; if_pc = 32'h118;
        tick();
        // hazard present, but flush takes priority and is not counted
        flush = 1; if_instr = I_ADD_X6; if_pc = 32'h11C;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL fl_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%0b exp=0", ex_valid); end
        checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL fl_stall got=%0d exp=2", stall_cycles); end
        idle_inputs();
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_instr !== I_LW_X5) begin failures++; $display("FAIL fl_dropped got=%0b/%h exp=0/%h", ex_valid, ex_instr, I_LW_X5); end
    endtask

    task automatic test_x0_and_imm();
        idle_inputs();
        if_valid = 1; if_instr = I_ADD_X7; if_pc = 32'h120;
        rf_rdata1 = 32'hFFFF_FFFF; rf_rdata2 = 32'hFFFF_FFFF;
        wb_write = 1; wb_rd = 5'd0; wb_data = 32'h55;
        tick();
        checks++; if (ex_op1 !== 32'h0 || ex_op2 !== 32'h0) begin failures++; $display("FAIL x0_ops got=%h,%h exp=0,0", ex_op1, ex_op2); end
        checks++; if (ex_rd !== 5'd7) begin failures++; $display("FAIL x0_rd got=%0d exp=7", ex_rd); end
        if_instr = I_BEQ_M8; if_pc = 32'h124;
        tick();
        checks++; if (ex_imm !== 32'hFFFF_FFF8) begin failures++; $display("FAIL beq_imm got=%h exp=fffffff8", ex_imm); end
        checks++; if (ex_reg_write !== 1'b0 || ex_rd !== 5'd0) begin failures++; $display("FAIL beq_wr got=%0b/%0d exp=0/0", ex_reg_write, ex_rd); end
        if_instr = I_LUI_X8; if_pc = 32'h128;
        tick();
        checks++; if (ex_imm !== 32'hABCD_E000) begin failures++; $display("FAIL lui_imm got=%h exp=abcde000", ex_imm); end
        checks++; if (ex_rd !== 5'd8 || ex_reg_write !== 1'b1) begin failures++; $display("FAIL lui_rd got=%0d/%0b exp=8/1", ex_rd, ex_reg_write); end
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        #2;
        test_reset();
        test_ex_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_x0_and_imm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
